// File: rtl/serial_bit_streamer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clk out on x.
// Optional macro PARITY_EN appends an even-parity bit after each word.
module serial_bit_streamer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic [WIDTH-1:0] sr;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sr_shifted;
`ifdef PARITY_EN
   logic             par;
`endif

   // Shift toward whichever end feeds x; the vacated bit fills with zero.
   assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

   // Ready depends only on flops, so an upstream valid can never loop back into ready.
   assign load_ready = ~hold_full;
   assign busy       = (state != IDLE) | hold_full;

   // NOTE: all state updates use non-blocking assignments so every branch sees the
   // pre-edge values of hold_full/sr/cnt regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         hold_data <= '0;
         hold_full <= 1'b0;
         sr        <= '0;
         cnt       <= '0;
`ifdef PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         // Accept and drain are mutually exclusive: accept needs hold_full=0, drain needs 1.
         if (load_valid && !hold_full) begin
            hold_data <= load_data;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (hold_full) begin
                  sr        <= hold_data;
                  hold_full <= 1'b0;
                  cnt       <= '0;
`ifdef PARITY_EN
                  par       <= ^hold_data;
`endif
                  state     <= SHIFT;
               end
            end

            SHIFT: begin
               if (cnt == LAST_CNT) begin
`ifdef PARITY_EN
                  state <= PARITY;
`else
                  if (hold_full) begin
                     sr        <= hold_data;
                     hold_full <= 1'b0;
                     cnt       <= '0;
                  end else begin
                     state <= IDLE;
                  end
`endif
               end else begin
                  sr  <= sr_shifted;
                  cnt <= cnt + 1'b1;
               end
            end

`ifdef PARITY_EN
            PARITY: begin
               if (hold_full) begin
                  sr        <= hold_data;
                  hold_full <= 1'b0;
                  cnt       <= '0;
                  par       <= ^hold_data;
                  state     <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are a pure decode of flops, so reset forces x to IDLE_BIT asynchronously.
   // NOTE: defaults first in always_comb so no path through the case infers a latch.
   always_comb begin
      x         = IDLE_BIT;
      x_valid   = 1'b0;
      word_done = 1'b0;
      case (state)
         SHIFT: begin
            x       = MSB_FIRST ? sr[WIDTH-1] : sr[0];
            x_valid = 1'b1;
`ifndef PARITY_EN
            word_done = (cnt == LAST_CNT);
`endif
         end
`ifdef PARITY_EN
         PARITY: begin
            x         = par;
            x_valid   = 1'b1;
            word_done = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Directed self-checking bench for serial_bit_streamer (MSB-first and LSB-first instances).
// Honours PARITY_EN when defined for the whole build.
module tb_serial_bit_streamer;

   localparam int W = 8;
`ifdef PARITY_EN
   localparam int P = W + 1;
`else
   localparam int P = W;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;

   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [W-1:0] load_data = '0;
   logic         x, x_valid, busy, word_done;

   logic         load_valid_l = 1'b0;
   logic         load_ready_l;
   logic [W-1:0] load_data_l = '0;
   logic         x_l, x_valid_l, busy_l, word_done_l;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_bit_streamer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .x          (x),
      .x_valid    (x_valid),
      .busy       (busy),
      .word_done  (word_done)
   );

   serial_bit_streamer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_lsb (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_valid (load_valid_l),
      .load_ready (load_ready_l),
      .load_data  (load_data_l),
      .x          (x_l),
      .x_valid    (x_valid_l),
      .busy       (busy_l),
      .word_done  (word_done_l)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Offer one word and hold it until the handshake edge; load_valid stays high afterwards.
   task automatic push(input logic [W-1:0] w);
      int t;
      t = 0;
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = w;
      while (!load_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("push_timeout", t, 0);
      @(posedge clk);
      #1;
   endtask

   // Send one or two words and compare the serial stream bit by bit against a hand-built list.
   task automatic stream_check(input logic [W-1:0] w0, input logic [W-1:0] w1,
                               input int nw, input string tag);
      logic exp_q[$];
      int   t;
      exp_q = {};
      for (int j = 0; j < nw; j++) begin
         logic [W-1:0] w;
         w = (j == 0) ? w0 : w1;
         for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PARITY_EN
         exp_q.push_back(^w);
`endif
      end
      fork
         begin
            push(w0);
            if (nw > 1) push(w1);
            load_valid = 1'b0;
         end
         begin
            t = 0;
            @(negedge clk);
            while (!x_valid && t < 40) begin
               @(negedge clk);
               t++;
            end
            check({tag, "_start"}, 32'(t < 40), 1);
            for (int k = 0; k < exp_q.size(); k++) begin
               if (k > 0) @(negedge clk);
               check($sformatf("%s_x%0d", tag, k), x, exp_q[k]);
               check($sformatf("%s_xv%0d", tag, k), x_valid, 1);
               check($sformatf("%s_wd%0d", tag, k), word_done, 32'((k % P) == P - 1));
               if (k == 0) check({tag, "_busy"}, busy, 1);
               if (k == 1) check({tag, "_ready"}, load_ready, 32'(nw == 1));
            end
            @(negedge clk);
            check({tag, "_end_xv"}, x_valid, 0);
            check({tag, "_end_x"}, x, 0);
            check({tag, "_end_busy"}, busy, 0);
            check({tag, "_end_wd"}, word_done, 0);
         end
      join
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int       t;
      int       vcount;
      logic     y, early_y;
      logic [2:0] hist;
      logic [W-1:0] lsb_exp;

      // Reset state
      #1;
      check("rst_x", x, 0);
      check("rst_xv", x_valid, 0);
      check("rst_wd", word_done, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", load_ready, 1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Single word, MSB first: A5 -> 1,0,1,0,0,1,0,1
      stream_check(8'hA5, 8'h00, 1, "a5");
      // Back-to-back words with no gap
      stream_check(8'h12, 8'h34, 2, "b2b");
      // Parity-relevant words (odd and even weight)
      stream_check(8'h07, 8'h00, 1, "w07");
      stream_check(8'h03, 8'h00, 1, "w03");

      // LSB-first instance: 01 -> 1 then seven 0s
      lsb_exp = 8'h01;
      @(negedge clk);
      load_valid_l = 1'b1;
      load_data_l  = 8'h01;
      @(posedge clk);
      #1;
      load_valid_l = 1'b0;
      t = 0;
      @(negedge clk);
      while (!x_valid_l && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("lsb_start", 32'(t < 20), 1);
      for (int k = 0; k < W; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("lsb_x%0d", k), x_l, lsb_exp[k]);
         check($sformatf("lsb_wd%0d", k), word_done_l, 32'(k == W - 1));
      end
`ifdef PARITY_EN
      @(negedge clk);
      check("lsb_par", x_l, 1);
`endif
      @(negedge clk);
      check("lsb_end_xv", x_valid_l, 0);

      // Reset mid-word with a second word held
      push(8'hFF);
      push(8'hAA);
      load_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_x", x, 0);
      check("mid_rst_xv", x_valid, 0);
      check("mid_rst_ready", load_ready, 1);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      vcount = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (x_valid || x) vcount++;
      end
      check("post_rst_quiet", vcount, 0);

      // 1001 detector fed by the stream: y must fire on the final bit of 09 only
      push(8'h09);
      load_valid = 1'b0;
      hist    = 3'b000;
      early_y = 1'b0;
      t = 0;
      @(negedge clk);
      while (!x_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("det_start", 32'(t < 20), 1);
      for (int k = 0; k < P; k++) begin
         if (k > 0) @(negedge clk);
         y = x_valid && ({hist, x} == 4'b1001);
         if (k == W - 1) check("det_final", y, 1);
         else if (k < W - 1) early_y = early_y | y;
         if (x_valid) hist = {hist[1:0], x};
      end
      check("det_early", early_y, 0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
